// File: rtl/counter_pkg.sv
// Shared constants and load clamp for the parametrised up/down counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic logic [15:0] clamp_load(
    input logic [15:0] v,
    input logic [15:0] max_v
  );
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/toggle_ff_async.sv
// One-bit toggle flip-flop, asynchronous active-high clear.
module toggle_ff_async (
  input  logic clk_i,
  input  logic rst_i,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/up_down_counter_param.sv
// Modulo-N up/down counter on a T flip-flop chain.
// Load beats count; optional saturation; cascade via carry_out.
module up_down_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clock_signal,
  input  logic             reset_signal,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             at_boundary
);

  localparam logic [WIDTH-1:0] MaxV =
    WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] lv_c;
  logic             dir_up;

  assign dir_up = (up_down == DIR_UP);

  assign lv_c = WIDTH'(clamp_load(
    16'(load_value), 16'(MODULUS - 1)));

  assign at_boundary = dir_up
    ? (count_q == MaxV)
    : (count_q == '0);

  assign carry_out = enable & at_boundary;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = lv_c;
    end else if (enable) begin
      if (at_boundary) begin
        if (SATURATE == MODE_SAT) begin
          count_d = count_q;
        end else begin
          count_d = dir_up ? '0 : MaxV;
        end
      end else if (dir_up) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Each bit toggles exactly where current and next state differ.
  assign t = count_q ^ count_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    toggle_ff_async u_tff (
      .clk_i (clock_signal),
      .rst_i (reset_signal),
      .t_i   (t[i]),
      .q_o   (count_q[i])
    );
  end

  assign count = count_q;

endmodule
